// File: rtl/seq_check_pkg.sv
// Shared state encoding for the sequence checker.
package seq_check_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module seq_sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {WIDTH{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/sequence_checker.sv
// Locks onto an arithmetic Number stream and flags mismatches while locked.
// SEQ_CHECK_ERRCNT_EN builds the ErrCount counter; without it ErrCount reads 0.
module sequence_checker
   import seq_check_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int STEP       = 1,
   parameter int LOCK_COUNT = 3,
   parameter int MISS_LIMIT = 2,
   parameter int ERR_W      = 8
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic               Valid,
   input  logic [WIDTH-1:0]   Number,
   input  logic               Clear,
   output logic               Locked,
   output logic               Error,
   output logic [WIDTH-1:0]   Expected,
   output logic [ERR_W-1:0]   ErrCount,
   output logic [STATE_W-1:0] dbg_state
);

   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
   localparam int MC_W = $clog2(LOCK_COUNT + 1);
   localparam int MS_W = $clog2(MISS_LIMIT + 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] exp_q, exp_nxt;
   logic [MC_W-1:0]  match_cnt, match_nxt;
   logic [MS_W-1:0]  miss_cnt, miss_nxt;
   logic             error_q, error_nxt;
   logic             err_inc;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state     <= HUNT;
         exp_q     <= '0;
         match_cnt <= '0;
         miss_cnt  <= '0;
         error_q   <= 1'b0;
      end else begin
         state     <= state_nxt;
         exp_q     <= exp_nxt;
         match_cnt <= match_nxt;
         miss_cnt  <= miss_nxt;
         error_q   <= error_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      exp_nxt   = exp_q;
      match_nxt = match_cnt;
      miss_nxt  = miss_cnt;
      error_nxt = 1'b0;
      err_inc   = 1'b0;
      if (Valid) begin
         case (state)
            HUNT: begin
               exp_nxt   = Number + STEP_W;
               match_nxt = '0;
               state_nxt = VERIFY;
            end
            VERIFY: begin
               if (Number == exp_q) begin
                  exp_nxt = exp_q + STEP_W;
                  if (match_cnt == MC_W'(LOCK_COUNT - 1)) begin
                     state_nxt = LOCKED;
                     match_nxt = '0;
                  end else begin
                     match_nxt = match_cnt + 1'b1;
                  end
               end else begin
                  exp_nxt   = Number + STEP_W;
                  match_nxt = '0;
               end
            end
            LOCKED: begin
               // Flywheel: keep predicting from our own count, never reseed here.
               exp_nxt = exp_q + STEP_W;
               if (Number == exp_q) begin
                  miss_nxt = '0;
               end else begin
                  error_nxt = 1'b1;
                  err_inc   = 1'b1;
                  if (miss_cnt == MS_W'(MISS_LIMIT - 1)) begin
                     state_nxt = HUNT;
                     miss_nxt  = '0;
                  end else begin
                     miss_nxt = miss_cnt + 1'b1;
                  end
               end
            end
            default: state_nxt = HUNT;
         endcase
      end
   end

   assign Locked    = (state == LOCKED);
   assign Error     = error_q;
   assign Expected  = exp_q;
   assign dbg_state = state;

`ifdef SEQ_CHECK_ERRCNT_EN
   seq_sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
      .clk   (CLK),
      .rst_n (Reset),
      .inc   (err_inc),
      .clr   (Clear),
      .count (ErrCount)
   );
`else
   logic unused_errcnt;
   assign unused_errcnt = Clear ^ err_inc;
   assign ErrCount      = '0;
`endif

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker: default instance plus a small-ERR_W instance.
module tb_sequence_checker;
   import seq_check_pkg::*;

`ifdef SEQ_CHECK_ERRCNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic         CLK;
   logic         Reset;
   logic         Valid, Clear;
   logic [3:0]   Number;
   logic         Locked, Error;
   logic [3:0]   Expected;
   logic [7:0]   ErrCount;
   logic [1:0]   dbg_state;

   logic         v2, c2;
   logic [3:0]   n2;
   logic         locked2, error2;
   logic [3:0]   expected2;
   logic [1:0]   errcount2;
   logic [1:0]   state2;

   int total = 0;
   int bad   = 0;

   sequence_checker dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .Valid     (Valid),
      .Number    (Number),
      .Clear     (Clear),
      .Locked    (Locked),
      .Error     (Error),
      .Expected  (Expected),
      .ErrCount  (ErrCount),
      .dbg_state (dbg_state)
   );

   sequence_checker #(.ERR_W(2), .MISS_LIMIT(8)) dut_sat (
      .CLK       (CLK),
      .Reset     (Reset),
      .Valid     (v2),
      .Number    (n2),
      .Clear     (c2),
      .Locked    (locked2),
      .Error     (error2),
      .Expected  (expected2),
      .ErrCount  (errcount2),
      .dbg_state (state2)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input logic v, input logic [3:0] n, input logic c);
      @(negedge CLK);
      Valid  = v;
      Number = n;
      Clear  = c;
      @(posedge CLK);
      #1;
   endtask

   task automatic step2(input logic v, input logic [3:0] n, input logic c);
      @(negedge CLK);
      v2 = v;
      n2 = n;
      c2 = c;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      Reset = 1'b0; Valid = 1'b0; Number = '0; Clear = 1'b0;
      v2 = 1'b0; n2 = '0; c2 = 1'b0;
      #2;
      chk("rst_locked", 32'(Locked), 0);
      chk("rst_error", 32'(Error), 0);
      chk("rst_expected", 32'(Expected), 0);
      chk("rst_errcount", 32'(ErrCount), 0);
      chk("rst_state", 32'(dbg_state), 32'(HUNT));
      @(negedge CLK);
      Reset = 1'b1;

      // 1: acquire lock on 0,1,2,3 then run through the wrap
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 4'(i), 1'b0);
         chk("acq_locked", 32'(Locked), (i == 3) ? 1 : 0);
      end
      chk("acq_expected", 32'(Expected), 4);
      for (int i = 4; i < 16; i++) begin
         step(1'b1, 4'(i), 1'b0);
         chk("run_error", 32'(Error), 0);
      end
      chk("wrap_expected", 32'(Expected), 0);
      step(1'b1, 4'd0, 1'b0);
      step(1'b1, 4'd1, 1'b0);
      chk("wrap_locked", 32'(Locked), 1);
      chk("wrap_error", 32'(Error), 0);
      chk("wrap_expected2", 32'(Expected), 2);

      // 2: single miss while expecting 7
      for (int i = 2; i < 7; i++) step(1'b1, 4'(i), 1'b0);
      chk("pre_miss_exp", 32'(Expected), 7);
      step(1'b1, 4'd9, 1'b0);
      chk("miss_error", 32'(Error), 1);
      chk("miss_locked", 32'(Locked), 1);
      chk("miss_expected", 32'(Expected), 8);
      chk("miss_errcount", 32'(ErrCount), CNT_EN ? 1 : 0);
      step(1'b1, 4'd8, 1'b0);
      chk("recover_error", 32'(Error), 0);
      chk("recover_locked", 32'(Locked), 1);
      chk("recover_expected", 32'(Expected), 9);

      // 3: two consecutive misses drop lock, then reacquire on 5..8
      step(1'b1, 4'd0, 1'b0);
      chk("drop1_error", 32'(Error), 1);
      chk("drop1_locked", 32'(Locked), 1);
      step(1'b1, 4'd0, 1'b0);
      chk("drop2_error", 32'(Error), 1);
      chk("drop2_locked", 32'(Locked), 0);
      chk("drop2_state", 32'(dbg_state), 32'(HUNT));
      chk("drop2_errcount", 32'(ErrCount), CNT_EN ? 3 : 0);
      for (int i = 5; i < 9; i++) begin
         step(1'b1, 4'(i), 1'b0);
         chk("relock_locked", 32'(Locked), (i == 8) ? 1 : 0);
         chk("relock_error", 32'(Error), 0);
      end
      chk("relock_expected", 32'(Expected), 9);

      // 4: Valid low holds Expected at 4
      for (int i = 9; i < 20; i++) step(1'b1, 4'(i), 1'b0);
      chk("hold_pre_exp", 32'(Expected), 4);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 4'd11, 1'b0);
         chk("hold_expected", 32'(Expected), 4);
         chk("hold_error", 32'(Error), 0);
      end
      step(1'b1, 4'd4, 1'b0);
      chk("hold_resume_err", 32'(Error), 0);
      chk("hold_resume_exp", 32'(Expected), 5);
      chk("hold_resume_lock", 32'(Locked), 1);
      step(1'b0, 4'd0, 1'b0);

      // 5: saturation and clear priority on the ERR_W=2 instance
      for (int i = 0; i < 4; i++) step2(1'b1, 4'(i), 1'b0);
      chk("sat_locked", 32'(locked2), 1);
      for (int i = 0; i < 5; i++) begin
         step2(1'b1, 4'd15, 1'b0);
         chk("sat_errcount", 32'(errcount2), CNT_EN ? ((i < 3) ? i + 1 : 3) : 0);
         chk("sat_error", 32'(error2), 1);
      end
      chk("sat_still_locked", 32'(locked2), 1);
      step2(1'b1, 4'd15, 1'b1);
      chk("clr_errcount", 32'(errcount2), 0);
      chk("clr_error", 32'(error2), 1);
      step2(1'b0, 4'd0, 1'b0);

      // 6: asynchronous reset mid-cycle while locked
      chk("pre_arst_locked", 32'(Locked), 1);
      @(posedge CLK);
      #3;
      Reset = 1'b0;
      #1;
      chk("arst_locked", 32'(Locked), 0);
      chk("arst_expected", 32'(Expected), 0);
      chk("arst_errcount", 32'(ErrCount), 0);
      chk("arst_state", 32'(dbg_state), 32'(HUNT));
      chk("arst_sat_count", 32'(errcount2), 0);
      @(negedge CLK);
      Reset = 1'b1;
      step(1'b0, 4'd0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
